uart_operand_sequencer: RTL and testbench
=========================================

Name: uart_operand_sequencer

Overview:
Sequences UART traffic into and out of the pipeline's register-file UART ports. It collects two received operand bytes and writes them one at a time via the signal/flag/data strobe. It then raises the interrupt request consumed by ID, waits for the kernel handler to acknowledge, and transmits the result byte back through the UART transmitter. It sits between the UART RX/TX cores and the CPU (ID and MEM stages).

Parameters:
TIMEOUT_CYCLES, 32'd5_000_000, max cycles between operand bytes before abort (used only with the optional feature)
TX_SETTLE, 4'd2, cycles waited after irq_clear before sampling result_data

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
rx_valid  input  1  one-cycle pulse: new byte on rx_byte
rx_byte  input  8  received byte
irq_clear  input  1  one-cycle pulse from MEM: handler finished
result_data  input  8  result byte from the register file UART result port
tx_busy  input  1  UART transmitter busy
uart_signal  output  1  one-cycle write strobe to the register file
uart_flag  output  1  0 = operand register 1, 1 = operand register 2
uart_rx_data  output  8  operand byte being written
irq  output  1  interrupt request to ID, level
tx_start  output  1  one-cycle pulse starting a transmission
tx_data  output  8  byte to transmit, held until the next tx_start
overrun  output  1  sticky flag: byte dropped while busy

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low. On reset all outputs are 0, state is IDLE and all counters are 0.
- All outputs are registered.
- States:
  - IDLE: on rx_valid, next cycle uart_signal=1, uart_flag=0, uart_rx_data=rx_byte. Go to WAIT2.
  - WAIT2: on rx_valid, next cycle uart_signal=1, uart_flag=1, uart_rx_data=rx_byte. Go to RAISE.
  - RAISE: irq=1 from the cycle after entry. Hold irq until irq_clear is sampled. irq drops in the same cycle state moves to SETTLE.
  - SETTLE: count TX_SETTLE cycles, then latch result_data into tx_data. Go to SEND.
  - SEND: when tx_busy=0, pulse tx_start for one cycle. Go to DRAIN.
  - DRAIN: once tx_busy is seen high and then low (or tx_busy=0 for 2 consecutive cycles after tx_start), go to IDLE.
- uart_signal is never high for two consecutive cycles. uart_flag and uart_rx_data remain stable after the strobe until the next strobe.
- irq_clear outside RAISE is ignored.
- rx_valid in RAISE, SETTLE, SEND or DRAIN: byte dropped, overrun set to 1. overrun stays set until reset.
- rx_valid and irq_clear in the same cycle in RAISE: clear is honoured and the byte is dropped with overrun=1.
- Byte latency: rx_valid to uart_signal is exactly 1 cycle. irq_clear to tx_start is TX_SETTLE+1 cycles minimum, extended while tx_busy=1.
- Reset asserted mid-sequence: immediate return to IDLE, irq=0, partial operand discarded. A tx_start already issued is not retracted.

Optional Feature:
Macro: UART_SEQ_TIMEOUT_EN
- Defined: a 32-bit counter runs in WAIT2 and clears on entry. If it reaches TIMEOUT_CYCLES-1 without rx_valid, go to IDLE with no second strobe and no irq. The counter saturates and does not wrap.
- Undefined: WAIT2 waits indefinitely. No counter logic is generated.

Decomposition:
- Shared package uart_seq_pkg:
  - state encoding: IDLE=3'd0, WAIT2=3'd1, RAISE=3'd2, SETTLE=3'd3, SEND=3'd4, DRAIN=3'd5
  - constants FLAG_OP1=1'b0, FLAG_OP2=1'b1
- One natural sub-module: uart_seq_timer, a loadable down-counter shared by the SETTLE count and the optional timeout.

Test Plan:
- Bytes 0x0C, 0x08 spaced 20 cycles apart → two uart_signal pulses with (flag 0, 0x0C) then (flag 1, 0x08). irq rises 1 cycle after the second strobe.
- In RAISE, result_data=0x04 and irq_clear pulses → irq low next cycle. tx_start exactly TX_SETTLE+1 cycles later with tx_data=0x04.
- tx_busy held high for 50 cycles at SEND → tx_start is delayed until tx_busy falls, then fires exactly once.
- Byte 0x55 arriving during RAISE → no uart_signal, overrun=1. overrun is still 1 after the sequence returns to IDLE.
- rst_n pulsed low after the first byte (in WAIT2) → all outputs 0 immediately. The next two bytes 0x01, 0x02 produce flags 0 then 1.
- With UART_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, one byte only → back to IDLE at cycle 100 with irq never asserted. The next byte is written with flag 0.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART operand sequencer.
// Optional feature macro: UART_SEQ_TIMEOUT_EN widens the shared timer to 32 bits
// so it can also time out a missing second operand byte.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT2  = 3'd1,
        ST_RAISE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SEND   = 3'd4,
        ST_DRAIN  = 3'd5
    } seq_state_e;

    localparam logic FLAG_OP1 = 1'b0;
    localparam logic FLAG_OP2 = 1'b1;

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int unsigned TMR_W = 32;
`else
    localparam int unsigned TMR_W = 4;
`endif

    // The timer reports terminal count while holding zero, so a wait of N
    // cycles is loaded as N-1. A zero wait still costs the one entry cycle.
    function automatic logic [TMR_W-1:0] settle_load(input logic [3:0] settle);
        logic [TMR_W-1:0] val;
        val = '0;
        if (settle != 4'd0) begin
            val = TMR_W'(settle - 4'd1);
        end
        return val;
    endfunction

endpackage

// File: rtl/uart_seq_timer.sv
// Loadable down-counter with terminal-count flag. Holds at zero (no wrap).
// Shared by the result settle wait and, with UART_SEQ_TIMEOUT_EN, the
// second-operand timeout.
module uart_seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/uart_operand_sequencer.sv
// UART operand sequencer: collects two operand bytes from the UART receiver,
// writes them into the register file, raises irq, waits for the handler's
// clear and sends the result byte through the UART transmitter.
// Optional feature macro: UART_SEQ_TIMEOUT_EN (abort a sequence whose second
// operand byte does not arrive within TIMEOUT_CYCLES).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for operand 1
// ST_WAIT2  | operand 1 written, waiting for operand 2
// ST_RAISE  | both operands written, irq held until irq_clear
// ST_SETTLE | letting the handler's result settle before sampling it
// ST_SEND   | result latched, waiting for the transmitter to go idle
// ST_DRAIN  | tx_start issued, waiting for the transmission to finish
module uart_operand_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
    parameter logic [3:0]  TX_SETTLE      = 4'd2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_byte_i,
    input  logic       irq_clear_i,
    input  logic [7:0] result_data_i,
    input  logic       tx_busy_i,
    output logic       uart_signal_o,
    output logic       uart_flag_o,
    output logic [7:0] uart_rx_data_o,
    output logic       irq_o,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       overrun_o
);

    seq_state_e state_q, state_d;

    logic       sig_q, sig_d;
    logic       flag_q, flag_d;
    logic [7:0] rxd_q, rxd_d;
    logic       irq_q, irq_d;
    logic       txs_q, txs_d;
    logic [7:0] txd_q, txd_d;
    logic       ovr_q, ovr_d;
    logic       seen_busy_q, seen_busy_d;
    logic       drain_low_q, drain_low_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_tc;

    uart_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .tc_o       (tmr_tc)
    );

    // Next-state and registered-output logic for the sequence.
    always_comb begin
        state_d     = state_q;
        sig_d       = 1'b0;
        flag_d      = flag_q;
        rxd_d       = rxd_q;
        irq_d       = irq_q;
        txs_d       = 1'b0;
        txd_d       = txd_q;
        ovr_d       = ovr_q;
        seen_busy_d = seen_busy_q;
        drain_low_d = drain_low_q;
        tmr_load    = 1'b0;
        tmr_val     = settle_load(TX_SETTLE);
        tmr_dec     = 1'b0;

        // Any byte arriving after both operands are in is lost.
        if (rx_valid_i && (state_q inside {ST_RAISE, ST_SETTLE, ST_SEND, ST_DRAIN})) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    sig_d   = 1'b1;
                    flag_d  = FLAG_OP1;
                    rxd_d   = rx_byte_i;
                    state_d = ST_WAIT2;
`ifdef UART_SEQ_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_CYCLES - 32'd1;
`endif
                end
            end

            ST_WAIT2: begin
                // A byte on the cycle right after the first strobe would
                // produce back-to-back strobes, so it is dropped as an overrun.
                if (rx_valid_i && !sig_q) begin
                    sig_d   = 1'b1;
                    flag_d  = FLAG_OP2;
                    rxd_d   = rx_byte_i;
                    state_d = ST_RAISE;
                end else begin
                    if (rx_valid_i) begin
                        ovr_d = 1'b1;
                    end
`ifdef UART_SEQ_TIMEOUT_EN
                    if (tmr_tc) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end
            end

            ST_RAISE: begin
                if (irq_clear_i) begin
                    irq_d    = 1'b0;
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                end else begin
                    irq_d = 1'b1;
                end
            end

            ST_SETTLE: begin
                // The last settle cycle samples the result and, if the
                // transmitter is free, starts it straight away.
                if (tmr_tc) begin
                    txd_d = result_data_i;
                    if (!tx_busy_i) begin
                        txs_d       = 1'b1;
                        seen_busy_d = 1'b0;
                        drain_low_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_SEND: begin
                if (!tx_busy_i) begin
                    txs_d       = 1'b1;
                    seen_busy_d = 1'b0;
                    drain_low_d = 1'b0;
                    state_d     = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Done after a busy-then-idle transmitter, or after two idle
                // cycles if it never reports busy.
                if (tx_busy_i) begin
                    seen_busy_d = 1'b1;
                    drain_low_d = 1'b0;
                end else if (seen_busy_q || drain_low_q) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_low_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // Sequence state and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            sig_q       <= 1'b0;
            flag_q      <= 1'b0;
            rxd_q       <= 8'h00;
            irq_q       <= 1'b0;
            txs_q       <= 1'b0;
            txd_q       <= 8'h00;
            ovr_q       <= 1'b0;
            seen_busy_q <= 1'b0;
            drain_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            flag_q      <= flag_d;
            rxd_q       <= rxd_d;
            irq_q       <= irq_d;
            txs_q       <= txs_d;
            txd_q       <= txd_d;
            ovr_q       <= ovr_d;
            seen_busy_q <= seen_busy_d;
            drain_low_q <= drain_low_d;
        end
    end

    assign uart_signal_o  = sig_q;
    assign uart_flag_o    = flag_q;
    assign uart_rx_data_o = rxd_q;
    assign irq_o          = irq_q;
    assign tx_start_o     = txs_q;
    assign tx_data_o      = txd_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_uart_operand_sequencer.sv
// Self-checking bench for uart_operand_sequencer. Expected event cycles are
// derived from the sequence rules: strobe one cycle after each byte, irq one
// cycle after the second strobe, irq low one cycle after the clear, tx_start
// TX_SETTLE+1 cycles after the clear or one cycle after the transmitter frees.
`timescale 1ns/1ps
module tb_uart_operand_sequencer;

    localparam logic [3:0] TX_SETTLE = 4'd2;
    localparam int         ST        = 2;
    localparam int         TO        = 100;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_byte_i = 8'h00;
    logic       irq_clear_i = 1'b0;
    logic [7:0] result_data_i = 8'h00;
    logic       tx_busy_i = 1'b0;
    logic       uart_signal_o;
    logic       uart_flag_o;
    logic [7:0] uart_rx_data_o;
    logic       irq_o;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       overrun_o;

    uart_operand_sequencer #(
        .TIMEOUT_CYCLES (32'd100),
        .TX_SETTLE      (TX_SETTLE)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rx_valid_i     (rx_valid_i),
        .rx_byte_i      (rx_byte_i),
        .irq_clear_i    (irq_clear_i),
        .result_data_i  (result_data_i),
        .tx_busy_i      (tx_busy_i),
        .uart_signal_o  (uart_signal_o),
        .uart_flag_o    (uart_flag_o),
        .uart_rx_data_o (uart_rx_data_o),
        .irq_o          (irq_o),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;
    bit exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event monitor: records strobes, irq edges and tx_start with cycle stamps.
    int         sq_cyc[$];
    logic       sq_flg[$];
    logic [7:0] sq_dat[$];
    int         irq_rise[$];
    int         irq_fall[$];
    int         txs_cyc[$];
    logic [7:0] txs_dat[$];
    logic prev_sig = 1'b0, prev_irq = 1'b0, prev_txs = 1'b0;

    always @(negedge clk_i) begin
        if (uart_signal_o) begin
            chk("strobe_spacing", prev_sig, 0);
            sq_cyc.push_back(cyc);
            sq_flg.push_back(uart_flag_o);
            sq_dat.push_back(uart_rx_data_o);
        end
        if (tx_start_o) begin
            chk("txstart_width", prev_txs, 0);
            txs_cyc.push_back(cyc);
            txs_dat.push_back(tx_data_o);
        end
        if (irq_o && !prev_irq) irq_rise.push_back(cyc);
        if (!irq_o && prev_irq) irq_fall.push_back(cyc);
        prev_sig = uart_signal_o;
        prev_irq = irq_o;
        prev_txs = tx_start_o;
    end

    task automatic clear_logs();
        sq_cyc.delete(); sq_flg.delete(); sq_dat.delete();
        irq_rise.delete(); irq_fall.delete();
        txs_cyc.delete(); txs_dat.delete();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic pulse_rx(input int c, input logic [7:0] b);
        wait_until(c);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'($urandom);
    endtask

    // One full operand/result sequence. probe: 0 none, 1 byte in first RAISE
    // cycle, 2 byte together with irq_clear, 3 byte on the last DRAIN cycle.
    task automatic do_txn(input int start, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] res, input int gap, input int busy_len,
                          input int tx_len, input int probe, input bit stray_clr,
                          output int idle_at);
        int c2, cc, cb, s;
        result_data_i = res;
        pulse_rx(start, b1);
        if (stray_clr) begin
            wait_until(start + 1);
            irq_clear_i = 1'b1;
            @(posedge clk_i); #1;
            irq_clear_i = 1'b0;
        end
        c2 = start + gap;
        pulse_rx(c2, b2);
        if (probe == 1) begin
            pulse_rx(c2 + 1, 8'h55);
            exp_ovr = 1'b1;
        end
        cc = c2 + $urandom_range(3, 9);
        cb = cc + busy_len;
        if (busy_len > 0) begin
            wait_until(cc - 1);
            tx_busy_i = 1'b1;
        end
        wait_until(cc);
        irq_clear_i = 1'b1;
        if (probe == 2) begin
            rx_valid_i = 1'b1;
            rx_byte_i  = 8'h55;
            exp_ovr    = 1'b1;
        end
        @(posedge clk_i); #1;
        irq_clear_i = 1'b0;
        rx_valid_i  = 1'b0;
        if (busy_len > 0) begin
            wait_until(cb);
            tx_busy_i = 1'b0;
        end
        s = cc + ST + 1;
        if (busy_len > 0 && cb + 1 > s) s = cb + 1;
        if (tx_len > 0) begin
            wait_until(s);
            tx_busy_i = 1'b1;
            wait_until(s + tx_len);
            tx_busy_i = 1'b0;
            idle_at = s + tx_len + 1;
        end else begin
            idle_at = s + 2;
        end
        if (probe == 3) begin
            pulse_rx(idle_at - 1, 8'hA5);
            exp_ovr = 1'b1;
        end
        wait_until(idle_at);

        chk("strobe_count", sq_cyc.size(), 2);
        if (sq_cyc.size() >= 2) begin
            chk("op1_cycle", sq_cyc[0], start + 1);
            chk("op1_flag",  sq_flg[0], 0);
            chk("op1_data",  sq_dat[0], b1);
            chk("op2_cycle", sq_cyc[1], c2 + 1);
            chk("op2_flag",  sq_flg[1], 1);
            chk("op2_data",  sq_dat[1], b2);
        end
        chk("irq_rise_count", irq_rise.size(), 1);
        if (irq_rise.size() >= 1) chk("irq_rise_cycle", irq_rise[0], c2 + 2);
        chk("irq_fall_count", irq_fall.size(), 1);
        if (irq_fall.size() >= 1) chk("irq_fall_cycle", irq_fall[0], cc + 1);
        chk("txstart_count", txs_cyc.size(), 1);
        if (txs_cyc.size() >= 1) begin
            chk("txstart_cycle", txs_cyc[0], s);
            chk("txstart_data",  txs_dat[0], res);
        end
        chk("overrun",      overrun_o, exp_ovr);
        chk("txdata_hold",  tx_data_o, res);
        chk("flag_hold",    uart_flag_o, 1);
        chk("rxdata_hold",  uart_rx_data_o, b2);
        chk("irq_idle",     irq_o, 0);
        clear_logs();
    endtask

    task automatic rand_txn(input int start, input int probe, output int idle_at);
        int bl;
        bl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
        do_txn(start, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(2, 25),
               bl, $urandom_range(0, 4), probe, 1'($urandom_range(0, 1)), idle_at);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idle;
        int t;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_signal", uart_signal_o, 0);
        chk("rst_flag",   uart_flag_o, 0);
        chk("rst_rxdata", uart_rx_data_o, 0);
        chk("rst_irq",    irq_o, 0);
        chk("rst_txstart", tx_start_o, 0);
        chk("rst_txdata", tx_data_o, 0);
        chk("rst_overrun", overrun_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        clear_logs();

        do_txn(cyc + 2, 8'h0C, 8'h08, 8'h04, 20, 0, 0, 0, 1'b0, idle);
        t = idle + 1;
        do_txn(t, 8'($urandom), 8'($urandom), 8'($urandom), 5, 50, 2, 0, 1'b0, idle);
        for (int i = 0; i < 12; i++) begin
            t = idle + $urandom_range(0, 3);
            rand_txn(t, 0, idle);
        end

        do_txn(idle, 8'($urandom), 8'($urandom), 8'($urandom), 7, 0, 0, 3, 1'b0, idle);
        do_txn(idle, 8'($urandom), 8'($urandom), 8'($urandom), 9, 3, 1, 1, 1'b0, idle);
        for (int i = 0; i < 4; i++) begin
            t = idle + $urandom_range(0, 3);
            rand_txn(t, 0, idle);
        end

        t = idle + 1;
        pulse_rx(t, 8'h33);
        wait_until(t + 3);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_signal",  uart_signal_o, 0);
        chk("midrst_flag",    uart_flag_o, 0);
        chk("midrst_rxdata",  uart_rx_data_o, 0);
        chk("midrst_irq",     irq_o, 0);
        chk("midrst_txstart", tx_start_o, 0);
        chk("midrst_txdata",  tx_data_o, 0);
        chk("midrst_overrun", overrun_o, 0);
        exp_ovr = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        clear_logs();
        do_txn(cyc + 1, 8'h01, 8'h02, 8'($urandom), 6, 0, 0, 0, 1'b0, idle);
        do_txn(idle + 2, 8'($urandom), 8'($urandom), 8'($urandom), 4, 2, 3, 2, 1'b0, idle);
        for (int i = 0; i < 3; i++) begin
            t = idle + $urandom_range(0, 3);
            rand_txn(t, 0, idle);
        end

`ifdef UART_SEQ_TIMEOUT_EN
        t = idle + 2;
        pulse_rx(t, 8'h77);
        wait_until(t + 1 + TO);
        chk("timeout_strobe_count", sq_cyc.size(), 1);
        chk("timeout_irq_count", irq_rise.size(), 0);
        chk("timeout_irq", irq_o, 0);
        clear_logs();
        do_txn(t + 1 + TO, 8'($urandom), 8'($urandom), 8'($urandom), 3, 0, 0, 0, 1'b0, idle);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
